// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver holding one byte for a Wishbone classic read.
module uart_rx #(
  parameter int CLOCKS_PER_BIT = 868,
  parameter int DAT_WIDTH      = 8
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 wb_cyc_i,
  input  logic                 wb_stb_i,
  input  logic                 wb_we_i,
  output logic [DAT_WIDTH-1:0] wb_dat_o,
  output logic                 wb_ack_o,
  input  logic                 uart_rx_i,
  output logic                 frame_err_o,
  output logic                 overrun_o
);
  localparam int BW = $clog2(DAT_WIDTH + 1);
  localparam logic [31:0] HALF = 32'(CLOCKS_PER_BIT / 2 - 1);
  localparam logic [31:0] LAST = 32'(CLOCKS_PER_BIT - 1);
  localparam logic [BW-1:0] BLAST = BW'(DAT_WIDTH - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t               state_q;
  logic                 sync1_q, rxs_q, rxs_prev_q;
  logic [31:0]          baud_q;
  logic [BW-1:0]        bit_q;
  logic [DAT_WIDTH-1:0] shift_q, hold_q, dat_q;
  logic                 valid_q, ack_q, frame_err_q, overrun_q;
  logic                 req, take, rd_clr, wrap, load;
  assign req    = wb_cyc_i & wb_stb_i;
  assign take   = req & ~ack_q & (wb_we_i | valid_q);
  assign rd_clr = take & ~wb_we_i;
  assign wrap   = baud_q == LAST;
  assign load   = (state_q == STOP) & wrap & rxs_q;
  assign wb_dat_o    = dat_q;
  assign wb_ack_o    = ack_q;
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= IDLE;
      sync1_q     <= 1'b1;
      rxs_q       <= 1'b1;
      rxs_prev_q  <= 1'b1;
      baud_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      dat_q       <= '0;
      valid_q     <= 1'b0;
      ack_q       <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync1_q     <= uart_rx_i;
      rxs_q       <= sync1_q;
      rxs_prev_q  <= rxs_q;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      ack_q       <= take;
      if (rd_clr) dat_q <= hold_q;
      // a byte landing in the same cycle as a read clear keeps the flag set
      if (load) valid_q <= 1'b1;
      else if (rd_clr) valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          baud_q <= '0;
          if (rxs_prev_q && !rxs_q) state_q <= START;
        end
        START: begin
          if (baud_q == HALF) begin
            baud_q  <= '0;
            bit_q   <= '0;
            state_q <= rxs_q ? IDLE : DATA;
          end else baud_q <= baud_q + 32'd1;
        end
        DATA: begin
          if (wrap) begin
            baud_q  <= '0;
            shift_q <= {rxs_q, shift_q[DAT_WIDTH-1:1]};
            bit_q   <= bit_q + BW'(1);
            if (bit_q == BLAST) state_q <= STOP;
          end else baud_q <= baud_q + 32'd1;
        end
        STOP: begin
          if (wrap) begin
            baud_q  <= '0;
            state_q <= IDLE;
            if (rxs_q) begin
              hold_q    <= shift_q;
              overrun_q <= valid_q & ~rd_clr;
            end else frame_err_q <= 1'b1;
          end else baud_q <= baud_q + 32'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frame table plus hand-written corner sequences for uart_rx.
module tb_uart_rx;
  localparam int CPB = 4;
  typedef struct {
    logic [7:0] d;
    logic       stop;
    logic       err;
  } vec_t;
  logic       clk = 1'b0, rst = 1'b1, cyc = 1'b0, stb = 1'b0, we = 1'b0, rx = 1'b1;
  logic [7:0] dat;
  logic       ack, ferr, ovr;
  int total = 0, bad = 0, err_cnt = 0, ovr_cnt = 0, ack_cnt = 0;
  always #5 clk = ~clk;
  uart_rx #(.CLOCKS_PER_BIT(CPB), .DAT_WIDTH(8)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_dat_o(dat), .wb_ack_o(ack), .uart_rx_i(rx), .frame_err_o(ferr), .overrun_o(ovr)
  );
  always @(posedge clk) begin
    #1;
    if (ferr) err_cnt++;
    if (ovr) ovr_cnt++;
    if (ack) ack_cnt++;
  end
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", n, got, exp);
    end
  endtask
  task automatic send(input logic [7:0] d, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask
  task automatic rd(input int lim, output logic got, output logic [7:0] d);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; got = 1'b0; d = '0;
    for (int i = 0; i < lim && !got; i++) begin
      @(negedge clk);
      if (ack) begin got = 1'b1; d = dat; end
    end
    if (got) begin
      @(negedge clk);
      chk("ack_one_cycle", {31'd0, ack}, 0);
    end
    cyc = 1'b0; stb = 1'b0;
  endtask
  vec_t vt[5];
  logic got;
  logic [7:0] d;
  int e0, o0, a0;
  initial begin
    vt[0] = '{8'hA5, 1'b1, 1'b0};
    vt[1] = '{8'h5A, 1'b1, 1'b0};
    vt[2] = '{8'h00, 1'b1, 1'b0};
    vt[3] = '{8'hFF, 1'b1, 1'b0};
    vt[4] = '{8'h55, 1'b0, 1'b1};
    repeat (3) @(negedge clk);
    chk("rst_ack", {31'd0, ack}, 0);
    chk("rst_dat", {24'd0, dat}, 0);
    chk("rst_ferr", {31'd0, ferr}, 0);
    chk("rst_ovr", {31'd0, ovr}, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1;
    chk("wr_no_same_cycle", {31'd0, ack}, 0);
    @(negedge clk);
    chk("wr_ack", {31'd0, ack}, 1);
    @(negedge clk);
    chk("wr_ack_once", {31'd0, ack}, 0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    repeat (4) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      e0 = err_cnt; o0 = ovr_cnt;
      send(vt[k].d, vt[k].stop);
      repeat (4) @(negedge clk);
      chk($sformatf("v%0d_ferr", k), err_cnt - e0, {31'd0, vt[k].err});
      chk($sformatf("v%0d_ovr", k), ovr_cnt - o0, 0);
      rd(vt[k].err ? 20 : 50, got, d);
      chk($sformatf("v%0d_ack", k), {31'd0, got}, {31'd0, ~vt[k].err});
      if (!vt[k].err) chk($sformatf("v%0d_dat", k), {24'd0, d}, {24'd0, vt[k].d});
    end
    a0 = ack_cnt;
    fork
      rd(200, got, d);
      begin send(8'h3C, 1'b1); e0 = ack_cnt - a0; end
    join
    chk("stall_no_early_ack", e0, 0);
    chk("stall_ack", {31'd0, got}, 1);
    chk("stall_dat", {24'd0, d}, 32'h3C);
    e0 = err_cnt; o0 = ovr_cnt;
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    rd(10, got, d);
    chk("glitch_no_ack", {31'd0, got}, 0);
    chk("glitch_flags", (err_cnt - e0) + (ovr_cnt - o0), 0);
    o0 = ovr_cnt;
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    repeat (4) @(negedge clk);
    chk("overrun_once", ovr_cnt - o0, 1);
    rd(50, got, d);
    chk("overrun_ack", {31'd0, got}, 1);
    chk("overrun_dat", {24'd0, d}, 32'h22);
    e0 = err_cnt;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_ack", {31'd0, ack}, 0);
    repeat (60) @(negedge clk);
    rd(10, got, d);
    chk("rst_mid_no_byte", {31'd0, got}, 0);
    send(8'h0F, 1'b1);
    repeat (4) @(negedge clk);
    rd(50, got, d);
    chk("rst_then_ack", {31'd0, got}, 1);
    chk("rst_then_dat", {24'd0, d}, 32'h0F);
    chk("rst_no_ferr", err_cnt - e0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
